bsg_mem_2rw_sync_mask_write_byte_arb: RTL and testbench

- Request-side front end for the dual-port, byte-masked synchronous RAM.
- Accepts two independent valid/ready request streams (port a, port b) and serialises same-address conflicts, which the RAM cannot resolve.
- Drives the RAM ports and captures 1-cycle-latency read data into per-port response registers with valid/ready handshake.
- Sits between cache/DMA request logic and the hardened RAM.

---
 rtl/bsg_mem_2rw_sync_mask_write_byte_arb_pkg.sv | 27 ++
 rtl/bsg_mem_2rw_resp_slot.sv | 75 +++++++
 rtl/bsg_mem_2rw_sync_mask_write_byte_arb.sv | 137 +++++++++++++
 tb/tb_bsg_mem_2rw_sync_mask_write_byte_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_2rw_sync_mask_write_byte_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mem_2rw_sync_mask_write_byte_arb_pkg
// Description : Shared definitions for the dual-port byte-masked RAM request
//               arbiter: priority encoding and the same-address conflict test.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_mem_2rw_sync_mask_write_byte_arb_pkg;

    // Encoding of the collision-priority register (round-robin build only).
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    // Two requests on the same address conflict unless both are reads; the
    // RAM has no defined outcome for write/write or read/write to one word.
    function automatic logic is_collision(
        input logic a_v,
        input logic b_v,
        input logic a_w,
        input logic b_w,
        input logic addr_eq
    );
        return a_v & b_v & addr_eq & (a_w | b_w);
    endfunction

endpackage : bsg_mem_2rw_sync_mask_write_byte_arb_pkg
`default_nettype wire

// File: rtl/bsg_mem_2rw_resp_slot.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mem_2rw_resp_slot
// Description : Per-port read response slot. Tracks an in-flight read
//               (IDLE -> PEND -> HOLD), captures RAM read data in PEND and
//               presents it with valid/ready until consumed.
// Ports       : clk_i, reset_i (sync, active-low)
//               rd_accept_i    - a read was accepted on this port this cycle
//               mem_data_i     - RAM read data (valid the cycle after accept)
//               resp_ready_i   - consumer takes the response
//               slot_free_o    - a new read may be accepted this cycle
//               resp_v_o       - response valid
//               resp_data_o    - response data
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_mem_2rw_resp_slot #(
    parameter int WIDTH_P = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               rd_accept_i,
    input  logic [WIDTH_P-1:0] mem_data_i,
    input  logic               resp_ready_i,
    output logic               slot_free_o,
    output logic               resp_v_o,
    output logic [WIDTH_P-1:0] resp_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH_P-1:0] data_q,  data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (rd_accept_i) state_d = PEND;
            end
            PEND: begin
                // Only place the response register is written, so later RAM
                // traffic can never disturb a held response.
                data_d  = mem_data_i;
                state_d = HOLD;
            end
            HOLD: begin
                // A read accepted in the same cycle the response drains goes
                // straight back to PEND.
                if (resp_ready_i) state_d = rd_accept_i ? PEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign slot_free_o = (state_q == IDLE) || ((state_q == HOLD) && resp_ready_i);
    assign resp_v_o    = (state_q == HOLD) && reset_i;
    assign resp_data_o = data_q;

endmodule : bsg_mem_2rw_resp_slot
`default_nettype wire

// File: rtl/bsg_mem_2rw_sync_mask_write_byte_arb.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mem_2rw_sync_mask_write_byte_arb
// Description : Request front end for a dual-port byte-masked synchronous RAM.
//               Accepts two valid/ready request streams, stalls port b on a
//               same-address conflict, drives the RAM ports combinationally
//               and returns read data through per-port response slots.
// Ports       : clk_i, reset_i (sync, active-low)
//               {a,b}_v_i/_ready_o/_w_i/_addr_i/_data_i/_mask_i - requests
//               mem_{a,b}_v_o/_w_o/_addr_o/_data_o/_mask_o/_data_i - RAM side
//               {a,b}_resp_v_o/_resp_data_o/_resp_ready_i          - responses
// Options     : BSG_MEM_2RW_ARB_ROUND_ROBIN_EN - alternate the collision winner
//               with a 1-bit priority register (default: port a always wins).
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_mem_2rw_sync_mask_write_byte_arb
    import bsg_mem_2rw_sync_mask_write_byte_arb_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int els_p         = 16,
    parameter int addr_width_lp = $clog2(els_p),
    parameter int mask_width_lp = width_p >> 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     a_v_i,
    output logic                     a_ready_o,
    input  logic                     a_w_i,
    input  logic [addr_width_lp-1:0] a_addr_i,
    input  logic [width_p-1:0]       a_data_i,
    input  logic [mask_width_lp-1:0] a_mask_i,

    input  logic                     b_v_i,
    output logic                     b_ready_o,
    input  logic                     b_w_i,
    input  logic [addr_width_lp-1:0] b_addr_i,
    input  logic [width_p-1:0]       b_data_i,
    input  logic [mask_width_lp-1:0] b_mask_i,

    output logic                     mem_a_v_o,
    output logic                     mem_a_w_o,
    output logic [addr_width_lp-1:0] mem_a_addr_o,
    output logic [width_p-1:0]       mem_a_data_o,
    output logic [mask_width_lp-1:0] mem_a_mask_o,
    input  logic [width_p-1:0]       mem_a_data_i,

    output logic                     mem_b_v_o,
    output logic                     mem_b_w_o,
    output logic [addr_width_lp-1:0] mem_b_addr_o,
    output logic [width_p-1:0]       mem_b_data_o,
    output logic [mask_width_lp-1:0] mem_b_mask_o,
    input  logic [width_p-1:0]       mem_b_data_i,

    output logic                     a_resp_v_o,
    output logic [width_p-1:0]       a_resp_data_o,
    input  logic                     a_resp_ready_i,

    output logic                     b_resp_v_o,
    output logic [width_p-1:0]       b_resp_data_o,
    input  logic                     b_resp_ready_i
);

    logic a_slot_free, b_slot_free;
    logic a_ok, b_ok;
    logic collision;
    logic a_wins;
    logic a_fire, b_fire;

    // Writes never need a response slot; reads need one free this cycle.
    assign a_ok = a_w_i | a_slot_free;
    assign b_ok = b_w_i | b_slot_free;

    assign collision = is_collision(a_v_i, b_v_i, a_w_i, b_w_i, a_addr_i == b_addr_i);

`ifdef BSG_MEM_2RW_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;

    assign a_wins = (prio_q == PRIO_A);

    // Hand priority to the loser once the winner's request actually went
    // through; a collision where the winner itself stalled changes nothing.
    always_comb begin
        prio_d = prio_q;
        if (collision && (a_wins ? a_fire : b_fire)) prio_d = ~prio_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) prio_q <= PRIO_A;
        else          prio_q <= prio_d;
    end
`else
    assign a_wins = 1'b1;
`endif

    assign a_ready_o = reset_i & a_ok & ~(collision & ~a_wins);
    assign b_ready_o = reset_i & b_ok & ~(collision &  a_wins);

    assign a_fire = a_v_i & a_ready_o;
    assign b_fire = b_v_i & b_ready_o;

    assign mem_a_v_o    = a_fire;
    assign mem_a_w_o    = a_w_i;
    assign mem_a_addr_o = a_addr_i;
    assign mem_a_data_o = a_data_i;
    assign mem_a_mask_o = a_mask_i;

    assign mem_b_v_o    = b_fire;
    assign mem_b_w_o    = b_w_i;
    assign mem_b_addr_o = b_addr_i;
    assign mem_b_data_o = b_data_i;
    assign mem_b_mask_o = b_mask_i;

    bsg_mem_2rw_resp_slot #(.WIDTH_P(width_p)) u_slot_a (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rd_accept_i  (a_fire & ~a_w_i),
        .mem_data_i   (mem_a_data_i),
        .resp_ready_i (a_resp_ready_i),
        .slot_free_o  (a_slot_free),
        .resp_v_o     (a_resp_v_o),
        .resp_data_o  (a_resp_data_o)
    );

    bsg_mem_2rw_resp_slot #(.WIDTH_P(width_p)) u_slot_b (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rd_accept_i  (b_fire & ~b_w_i),
        .mem_data_i   (mem_b_data_i),
        .resp_ready_i (b_resp_ready_i),
        .slot_free_o  (b_slot_free),
        .resp_v_o     (b_resp_v_o),
        .resp_data_o  (b_resp_data_o)
    );

endmodule : bsg_mem_2rw_sync_mask_write_byte_arb
`default_nettype wire

// File: tb/tb_bsg_mem_2rw_sync_mask_write_byte_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_mem_2rw_sync_mask_write_byte_arb
// Description : Directed scoreboard bench for the dual-port RAM arbiter, with
//               a behavioural byte-masked RAM behind the mem_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_mem_2rw_sync_mask_write_byte_arb;

    localparam int W  = 32;
    localparam int E  = 16;
    localparam int AW = 4;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          a_v_i, a_ready_o, a_w_i, b_v_i, b_ready_o, b_w_i;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [W-1:0]  a_data_i, b_data_i;
    logic [MW-1:0] a_mask_i, b_mask_i;
    logic          mem_a_v_o, mem_a_w_o, mem_b_v_o, mem_b_w_o;
    logic [AW-1:0] mem_a_addr_o, mem_b_addr_o;
    logic [W-1:0]  mem_a_data_o, mem_b_data_o, mem_a_data_i, mem_b_data_i;
    logic [MW-1:0] mem_a_mask_o, mem_b_mask_o;
    logic          a_resp_v_o, b_resp_v_o, a_resp_ready_i, b_resp_ready_i;
    logic [W-1:0]  a_resp_data_o, b_resp_data_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ram [0:E-1];

    always #5 clk = ~clk;

    bsg_mem_2rw_sync_mask_write_byte_arb #(.width_p(W), .els_p(E)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .a_v_i(a_v_i), .a_ready_o(a_ready_o), .a_w_i(a_w_i), .a_addr_i(a_addr_i),
        .a_data_i(a_data_i), .a_mask_i(a_mask_i),
        .b_v_i(b_v_i), .b_ready_o(b_ready_o), .b_w_i(b_w_i), .b_addr_i(b_addr_i),
        .b_data_i(b_data_i), .b_mask_i(b_mask_i),
        .mem_a_v_o(mem_a_v_o), .mem_a_w_o(mem_a_w_o), .mem_a_addr_o(mem_a_addr_o),
        .mem_a_data_o(mem_a_data_o), .mem_a_mask_o(mem_a_mask_o), .mem_a_data_i(mem_a_data_i),
        .mem_b_v_o(mem_b_v_o), .mem_b_w_o(mem_b_w_o), .mem_b_addr_o(mem_b_addr_o),
        .mem_b_data_o(mem_b_data_o), .mem_b_mask_o(mem_b_mask_o), .mem_b_data_i(mem_b_data_i),
        .a_resp_v_o(a_resp_v_o), .a_resp_data_o(a_resp_data_o), .a_resp_ready_i(a_resp_ready_i),
        .b_resp_v_o(b_resp_v_o), .b_resp_data_o(b_resp_data_o), .b_resp_ready_i(b_resp_ready_i)
    );

    // Behavioural byte-masked RAM, one-cycle read latency.
    initial for (int i = 0; i < E; i++) ram[i] = '0;

    always @(posedge clk) begin
        if (mem_a_v_o) begin
            if (mem_a_w_o) begin
                for (int i = 0; i < MW; i++)
                    if (mem_a_mask_o[i]) ram[mem_a_addr_o][8*i +: 8] <= mem_a_data_o[8*i +: 8];
            end else mem_a_data_i <= ram[mem_a_addr_o];
        end
        if (mem_b_v_o) begin
            if (mem_b_w_o) begin
                for (int i = 0; i < MW; i++)
                    if (mem_b_mask_o[i]) ram[mem_b_addr_o][8*i +: 8] <= mem_b_data_o[8*i +: 8];
            end else mem_b_data_i <= ram[mem_b_addr_o];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed response is compared with the scoreboard head.
    always @(negedge clk) begin
        if (a_resp_v_o && a_resp_ready_i) begin
            if (qa.size() == 0) chk("a_resp_unexpected", a_resp_data_o, 'x);
            else chk("a_resp_data", a_resp_data_o, qa.pop_front());
        end
        if (b_resp_v_o && b_resp_ready_i) begin
            if (qb.size() == 0) chk("b_resp_unexpected", b_resp_data_o, 'x);
            else chk("b_resp_data", b_resp_data_o, qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_v_i = 0; a_w_i = 0; a_addr_i = '0; a_data_i = '0; a_mask_i = '0;
        b_v_i = 0; b_w_i = 0; b_addr_i = '0; b_data_i = '0; b_mask_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        idle_inputs();
        a_resp_ready_i = 0; b_resp_ready_i = 0;

        // Reset with both ports requesting.
        reset_i = 0; a_v_i = 1; b_v_i = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_a_ready", a_ready_o, 0);
        chk("rst_b_ready", b_ready_o, 0);
        chk("rst_mem_a_v", mem_a_v_o, 0);
        chk("rst_mem_b_v", mem_b_v_o, 0);
        chk("rst_a_resp_v", a_resp_v_o, 0);
        chk("rst_b_resp_v", b_resp_v_o, 0);
        tick();

        // Release: masked write to addr 5 accepted in the first cycle.
        reset_i = 1; idle_inputs();
        a_v_i = 1; a_w_i = 1; a_addr_i = 5; a_data_i = 32'hAABBCCDD; a_mask_i = 4'b0101;
        @(negedge clk);
        chk("first_a_ready", a_ready_o, 1);
        chk("first_mem_a_v", mem_a_v_o, 1);
        tick();

        // Read back addr 5; bytes 0 and 2 written.
        a_w_i = 0; a_data_i = '0; a_mask_i = '0;
        qa.push_back(32'h00BB00DD);
        @(negedge clk);
        chk("rd5_a_ready", a_ready_o, 1);
        tick();
        a_v_i = 0;
        @(negedge clk);
        chk("rd5_t1_resp_v", a_resp_v_o, 0);
        tick();
        @(negedge clk);
        chk("rd5_t2_resp_v", a_resp_v_o, 1);
        chk("rd5_t2_data", a_resp_data_o, 32'h00BB00DD);
        held = 32'h00BB00DD;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("rd5_hold_v", a_resp_v_o, 1);
            chk("rd5_hold_data", a_resp_data_o, held);
        end
        tick();
        a_resp_ready_i = 1;
        tick();
        @(negedge clk);
        chk("rd5_drained", a_resp_v_o, 0);

        // a writes addr 3 while b reads addr 3: b stalls one cycle.
        tick();
        a_v_i = 1; a_w_i = 1; a_addr_i = 3; a_data_i = 32'h11223344; a_mask_i = 4'hF;
        b_v_i = 1; b_w_i = 0; b_addr_i = 3; b_resp_ready_i = 1;
        @(negedge clk);
        chk("coll_a_ready", a_ready_o, 1);
        chk("coll_b_ready", b_ready_o, 0);
        tick();
        a_v_i = 0;
        qb.push_back(32'h11223344);
        @(negedge clk);
        chk("coll_b_retry_ready", b_ready_o, 1);
        tick();
        b_v_i = 0;
        tick();
        @(negedge clk);
        chk("coll_b_resp_v", b_resp_v_o, 1);
        tick();

        // Populate addr 7, then read it from both ports together.
        a_v_i = 1; a_w_i = 1; a_addr_i = 7; a_data_i = 32'hCAFEF00D; a_mask_i = 4'hF;
        tick();
        a_w_i = 0; b_v_i = 1; b_w_i = 0; b_addr_i = 7;
        qa.push_back(32'hCAFEF00D);
        qb.push_back(32'hCAFEF00D);
        @(negedge clk);
        chk("rr7_a_ready", a_ready_o, 1);
        chk("rr7_b_ready", b_ready_o, 1);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        chk("rr7_a_resp_v", a_resp_v_o, 1);
        chk("rr7_b_resp_v", b_resp_v_o, 1);
        chk("rr7_same_data", a_resp_data_o, 32'hCAFEF00D);
        chk("rr7_b_data", b_resp_data_o, 32'hCAFEF00D);
        tick();

        // Reset arrives while a read is pending: the read is dropped.
        a_resp_ready_i = 1;
        a_v_i = 1; a_w_i = 0; a_addr_i = 7;
        tick();
        a_v_i = 0;
        reset_i = 0;
        tick(); tick();
        reset_i = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pend_rst_resp_v", a_resp_v_o, 0);
            tick();
        end
        chk("pend_rst_data", a_resp_data_o, 0);

        // Persistent conflicting writes to addr 1 from both ports.
        a_v_i = 1; a_w_i = 1; a_addr_i = 1; a_data_i = 32'hA0A0A0A0; a_mask_i = 4'hF;
        b_v_i = 1; b_w_i = 1; b_addr_i = 1; b_data_i = 32'hB0B0B0B0; b_mask_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            logic exp_a;
`ifdef BSG_MEM_2RW_ARB_ROUND_ROBIN_EN
            exp_a = (k % 2) == 0;
`else
            exp_a = 1'b1;
`endif
            @(negedge clk);
            chk("cont_a_ready", a_ready_o, exp_a);
            chk("cont_b_ready", b_ready_o, !exp_a);
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bsg_mem_2rw_sync_mask_write_byte_arb
`default_nettype wire
